// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Optional statistics output is enabled with REGARB_STATS_EN.
package reg_write_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback-request / register-file-write bundle for reg_write_arbiter.
// conflictCount exists only when REGARB_STATS_EN is defined.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*ADDR_W-1:0] reqRd;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqReady;
  logic                      isWrite;
  logic [ADDR_W-1:0]         rd;
  logic [DATA_W-1:0]         writeData;
  logic                      busy;
`ifdef REGARB_STATS_EN
  logic [15:0]               conflictCount;
  modport master (output reqValid, reqRd, reqData,
                  input  reqReady, isWrite, rd, writeData, busy, conflictCount);
  modport slave  (input  reqValid, reqRd, reqData,
                  output reqReady, isWrite, rd, writeData, busy, conflictCount);
`else
  modport master (output reqValid, reqRd, reqData,
                  input  reqReady, isWrite, rd, writeData, busy);
  modport slave  (input  reqValid, reqRd, reqData,
                  output reqReady, isWrite, rd, writeData, busy);
`endif
endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Stateless round-robin picker: first held entry after ptr, wrapping modulo N.
module rr_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  held,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int  p;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    p     = int'(ptr);
    for (int k = 0; k < N; k++) begin
      p = rr_next(p, N);
      if (!found && held[p]) begin
        grant[p] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one register-file write port among NUM_REQ writeback sources via one-entry
// holding registers and a round-robin grant. REGARB_STATS_EN adds conflictCount.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = reg_write_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = reg_write_arbiter_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_REQ-1:0] held_q, held_d, grant, req_ready, store;
  entry_t             ent_q [NUM_REQ];
  entry_t             ent_d [NUM_REQ];
  entry_t             sel;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, gidx;
  logic               is_write_q, is_write_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .held (held_q),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  // A granted entry frees its slot this cycle, so it may be refilled at the same edge.
  assign req_ready = rst_n ? (~held_q | grant) : '0;

  always_comb begin
    sel  = '0;
    gidx = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel  = ent_q[i];
        gidx = PW'(i);
      end
    end
  end

  always_comb begin
    held_d = held_q;
    store  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ent_d[i] = ent_q[i];
      // Writes to x0 complete the handshake but are dropped here.
      store[i] = bus.reqValid[i] & req_ready[i] &
                 (bus.reqRd[i*ADDR_W +: ADDR_W] != '0);
      if (store[i]) begin
        held_d[i]     = 1'b1;
        ent_d[i].rd   = bus.reqRd[i*ADDR_W +: ADDR_W];
        ent_d[i].data = bus.reqData[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        held_d[i] = 1'b0;
      end
    end
    rr_ptr_d   = (|grant) ? gidx : rr_ptr_q;
    is_write_d = |grant;
    rd_d       = (|grant) ? sel.rd   : rd_q;
    wdata_d    = (|grant) ? sel.data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      rr_ptr_q   <= PW'(NUM_REQ - 1);
      is_write_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) ent_q[i] <= '0;
    end else begin
      held_q     <= held_d;
      rr_ptr_q   <= rr_ptr_d;
      is_write_q <= is_write_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      for (int i = 0; i < NUM_REQ; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign bus.reqReady  = req_ready;
  assign bus.isWrite   = is_write_q;
  assign bus.rd        = rd_q;
  assign bus.writeData = wdata_q;
  assign bus.busy      = (|held_q) | is_write_q;

`ifdef REGARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic        multi_held;

  assign multi_held = (held_q & (held_q - 1'b1)) != '0;

  always_comb begin
    conflict_d = conflict_q;
    if (multi_held && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign bus.conflictCount = conflict_q;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; inputs change and outputs are checked at negedge.
module tb_reg_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.reqValid[i]         = v;
    bus.reqRd[i*AW +: AW]   = r;
    bus.reqData[i*DW +: DW] = d;
  endtask

  task automatic clr_req();
    bus.reqValid = '0;
    bus.reqRd    = '0;
    bus.reqData  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clr_req();
    // 1: reset with all requesters valid
    bus.reqValid = 3'b111;
    tick();
    chk("rst_ready", 64'(bus.reqReady), 64'h0);
    chk("rst_iswr",  64'(bus.isWrite), 64'h0);
    chk("rst_rd",    64'(bus.rd), 64'h0);
    chk("rst_busy",  64'(bus.busy), 64'h0);
    clr_req();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(bus.reqReady), 64'h7);

    // 2: single write, isWrite visible one edge after the accept edge
    tick();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    clr_req();
    chk("sw_wait_iswr", 64'(bus.isWrite), 64'h0);
    chk("sw_wait_busy", 64'(bus.busy), 64'h1);
    tick();
    chk("sw_iswr", 64'(bus.isWrite), 64'h1);
    chk("sw_rd",   64'(bus.rd), 64'h5);
    chk("sw_data", 64'(bus.writeData), 64'hDEADBEEF);
    tick();
    chk("sw_iswr_off", 64'(bus.isWrite), 64'h0);
    chk("sw_busy_off", 64'(bus.busy), 64'h0);
    chk("sw_rd_hold",  64'(bus.rd), 64'h5);

    // 3: contention from a fresh pointer
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    tick();
    clr_req();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("ct_iswr%0d", k), 64'(bus.isWrite), 64'h1);
      chk($sformatf("ct_rd%0d", k),   64'(bus.rd), 64'(k));
      chk($sformatf("ct_data%0d", k), 64'(bus.writeData), 64'(k * 'h11));
    end
    set_req(0, 1'b1, 5'd1, 32'h44);
    set_req(2, 1'b1, 5'd3, 32'h66);
    tick();
    clr_req();
    chk("ct_gap", 64'(bus.isWrite), 64'h0);
    tick();
    chk("ct2_rd_a",   64'(bus.rd), 64'h1);
    chk("ct2_data_a", 64'(bus.writeData), 64'h44);
    tick();
    chk("ct2_rd_b",   64'(bus.rd), 64'h3);
    chk("ct2_data_b", 64'(bus.writeData), 64'h66);
    tick();
    chk("ct2_idle", 64'(bus.isWrite), 64'h0);

    // 4: x0 write dropped
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("x0_ready", 64'(bus.reqReady[1]), 64'h1);
    tick();
    clr_req();
    chk("x0_busy0", 64'(bus.busy), 64'h0);
    tick();
    chk("x0_iswr", 64'(bus.isWrite), 64'h0);
    chk("x0_busy1", 64'(bus.busy), 64'h0);

    // 5: back-to-back refill of requester 0, no bubbles
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 5'(4 + k), 32'(('h100) * (4 + k)));
      if (k > 0) begin
        #1;
        chk($sformatf("rf_ready%0d", k), 64'(bus.reqReady[0]), 64'h1);
      end
      tick();
      if (k > 0) begin
        chk($sformatf("rf_iswr%0d", k), 64'(bus.isWrite), 64'h1);
        chk($sformatf("rf_rd%0d", k),   64'(bus.rd), 64'(3 + k));
        chk($sformatf("rf_data%0d", k), 64'(bus.writeData), 64'('h100 * (3 + k)));
      end
    end
    clr_req();
    tick();
    chk("rf_last_rd", 64'(bus.rd), 64'd11);
    chk("rf_last_iswr", 64'(bus.isWrite), 64'h1);
    tick();
    chk("rf_end_iswr", 64'(bus.isWrite), 64'h0);

    // 6: async reset mid-burst
    set_req(0, 1'b1, 5'd7, 32'h7);
    set_req(1, 1'b1, 5'd8, 32'h8);
    set_req(2, 1'b1, 5'd9, 32'h9);
    tick();
    clr_req();
    tick();
    chk("mr_iswr_pre", 64'(bus.isWrite), 64'h1);
`ifdef REGARB_STATS_EN
    chk("mr_cc_pre", 64'(bus.conflictCount != 16'd0), 64'h1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_iswr_rst",  64'(bus.isWrite), 64'h0);
    chk("mr_busy_rst",  64'(bus.busy), 64'h0);
    chk("mr_ready_rst", 64'(bus.reqReady), 64'h0);
`ifdef REGARB_STATS_EN
    chk("mr_cc_rst", 64'(bus.conflictCount), 64'h0);
`endif
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_quiet%0d", k), 64'(bus.isWrite), 64'h0);
    end
    chk("mr_busy_post", 64'(bus.busy), 64'h0);
`ifdef REGARB_STATS_EN
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    tick();
    clr_req();
    chk("cc_accept", 64'(bus.conflictCount), 64'h0);
    tick();
    chk("cc_one", 64'(bus.conflictCount), 64'h1);
    tick();
    chk("cc_hold", 64'(bus.conflictCount), 64'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
